// File: rtl/utmi_tx_buffer.sv
// UTMI transmit buffer: FIFO-backed word stream to PHY DataOut/TxValid, one register stage in each direction.
// Upstream is stalled only by a full FIFO; the PHY paces output with TxReady; an underrun aborts and flushes the packet.
module utmi_tx_buffer #(
  parameter int DW          = 8,
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 4,
  parameter int IPG         = 2
) (
  input  logic                     phy_clk_pad_i,
  input  logic                     phy_rst_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     wr_last_i,
  input  logic                     wr_hi_i,
  output logic [DW-1:0]            DataOut_pad_o,
  output logic                     TxValid_pad_o,
  output logic                     TxValidH_pad_o,
  input  logic                     TxReady_pad_i,
  output logic                     busy_o,
  output logic                     underrun_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DW + 2;
  localparam int GW = $clog2(IPG + 1);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH, GAP} state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [LW-1:0]   count, pktCnt;
  logic [GW-1:0]   gapCnt;
  logic [EW-1:0]   head, wrEntry;
  logic            full, empty, wrEn, popEn, headLast, headHi, wrHiEff, outLast;

  assign full       = (count == LW'(DEPTH));
  assign empty      = (count == '0);
  assign wr_ready_o = !full && !phy_rst_i;
  assign wrEn       = wr_valid_i && wr_ready_o;
  // Non-last words always carry both bytes in 16-bit mode.
  assign wrHiEff    = (DW == 16) ? (wr_hi_i || !wr_last_i) : 1'b0;
  assign wrEntry    = {wrHiEff, wr_last_i, wr_data_i};
  assign head       = mem[rdPtr];
  assign headLast   = head[DW];
  assign headHi     = head[DW+1];
  assign busy_o     = (state != IDLE);
  assign level_o    = count;

  always_comb begin
    popEn = 1'b0;
    case (state)
      IDLE:    popEn = (count >= LW'(START_LEVEL)) || (pktCnt != '0);
      SEND:    popEn = TxReady_pad_i && !outLast && !empty;
      FLUSH:   popEn = !empty;
      default: popEn = 1'b0;
    endcase
  end

  always_ff @(posedge phy_clk_pad_i) begin
    if (wrEn) mem[wrPtr] <= wrEntry;
  end

  always_ff @(posedge phy_clk_pad_i) begin
    if (phy_rst_i) begin
      state          <= IDLE;
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      pktCnt         <= '0;
      gapCnt         <= '0;
      DataOut_pad_o  <= '0;
      outLast        <= 1'b0;
      TxValid_pad_o  <= 1'b0;
      TxValidH_pad_o <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (wrEn)  wrPtr <= wrPtr + PW'(1);
      if (popEn) rdPtr <= rdPtr + PW'(1);
      count  <= count + LW'(wrEn) - LW'(popEn);
      pktCnt <= pktCnt + LW'(wrEn && wr_last_i) - LW'(popEn && headLast);

      // Loads in IDLE and SEND go to the PHY; FLUSH pops are discarded.
      if (popEn && state != FLUSH) begin
        DataOut_pad_o  <= head[DW-1:0];
        outLast        <= headLast;
        TxValid_pad_o  <= 1'b1;
        TxValidH_pad_o <= (DW == 16) ? (!headLast || headHi) : 1'b0;
      end

      case (state)
        IDLE: if (popEn) state <= SEND;
        SEND: begin
          if (TxReady_pad_i) begin
            if (outLast) begin
              TxValid_pad_o  <= 1'b0;
              TxValidH_pad_o <= 1'b0;
              gapCnt         <= GW'(IPG);
              state          <= GAP;
            end else if (empty) begin
              TxValid_pad_o  <= 1'b0;
              TxValidH_pad_o <= 1'b0;
              underrun_o     <= 1'b1;
              state          <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!empty && headLast) begin
            gapCnt <= GW'(IPG);
            state  <= GAP;
          end
        end
        GAP: begin
          gapCnt <= gapCnt - GW'(1);
          if (gapCnt <= GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_utmi_tx_buffer.sv
// Directed bench: three buffer configurations (8-bit/16-deep, 16-bit, 8-bit/4-deep) on one clock and reset.
module tb_utmi_tx_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  // 8-bit, 16 deep
  logic       a_wv = 0, a_wrdy, a_wl = 0, a_txv, a_txvh, a_txr = 0, a_busy, a_und;
  logic [7:0] a_wd = 0, a_dout;
  logic [4:0] a_lvl;
  // 16-bit, 16 deep
  logic        b_wv = 0, b_wrdy, b_wl = 0, b_whi = 0, b_txv, b_txvh, b_txr = 0, b_busy, b_und;
  logic [15:0] b_wd = 0, b_dout;
  logic [4:0]  b_lvl;
  // 8-bit, 4 deep
  logic       c_wv = 0, c_wrdy, c_wl = 0, c_txv, c_txvh, c_txr = 0, c_busy, c_und;
  logic [7:0] c_wd = 0, c_dout;
  logic [2:0] c_lvl;

  utmi_tx_buffer #(.DW(8), .DEPTH(16), .START_LEVEL(4), .IPG(2)) uA (
    .phy_clk_pad_i(clk), .phy_rst_i(rst), .wr_valid_i(a_wv), .wr_ready_o(a_wrdy),
    .wr_data_i(a_wd), .wr_last_i(a_wl), .wr_hi_i(1'b0), .DataOut_pad_o(a_dout),
    .TxValid_pad_o(a_txv), .TxValidH_pad_o(a_txvh), .TxReady_pad_i(a_txr),
    .busy_o(a_busy), .underrun_o(a_und), .level_o(a_lvl));

  utmi_tx_buffer #(.DW(16), .DEPTH(16), .START_LEVEL(4), .IPG(2)) uB (
    .phy_clk_pad_i(clk), .phy_rst_i(rst), .wr_valid_i(b_wv), .wr_ready_o(b_wrdy),
    .wr_data_i(b_wd), .wr_last_i(b_wl), .wr_hi_i(b_whi), .DataOut_pad_o(b_dout),
    .TxValid_pad_o(b_txv), .TxValidH_pad_o(b_txvh), .TxReady_pad_i(b_txr),
    .busy_o(b_busy), .underrun_o(b_und), .level_o(b_lvl));

  utmi_tx_buffer #(.DW(8), .DEPTH(4), .START_LEVEL(4), .IPG(2)) uC (
    .phy_clk_pad_i(clk), .phy_rst_i(rst), .wr_valid_i(c_wv), .wr_ready_o(c_wrdy),
    .wr_data_i(c_wd), .wr_last_i(c_wl), .wr_hi_i(1'b0), .DataOut_pad_o(c_dout),
    .TxValid_pad_o(c_txv), .TxValidH_pad_o(c_txvh), .TxReady_pad_i(c_txr),
    .busy_o(c_busy), .underrun_o(c_und), .level_o(c_lvl));

  // Observed PHY acceptances and per-cycle statistics, sampled mid-cycle.
  int   accA[$], accB[$], accC[$];
  int   aTxvCyc = 0, aUndCyc = 0, aStab = 0;
  logic aPrevV = 0, aPrevAcc = 0;
  logic [7:0] aPrevD = 0;

  always @(negedge clk) begin
    if (rst) begin
      aPrevV = 1'b0;
    end else begin
      if (aPrevV && !aPrevAcc && a_txv && a_dout !== aPrevD) aStab++;
      if (a_txv && a_txr) accA.push_back(int'(a_dout));
      if (a_txv) aTxvCyc++;
      if (a_und) aUndCyc++;
      aPrevV   = a_txv;
      aPrevAcc = a_txv && a_txr;
      aPrevD   = a_dout;
      if (b_txv && b_txr) accB.push_back(int'({b_txvh, b_dout}));
      if (c_txv && c_txr) accC.push_back(int'(c_dout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wrA(input logic [7:0] d, input logic last);
    a_wv = 1'b1; a_wd = d; a_wl = last;
    for (int k = 0; k < 50; k++) begin
      if (a_wrdy) break;
      tick();
    end
    tick();
  endtask

  task automatic wrB(input logic [15:0] d, input logic last, input logic hi);
    b_wv = 1'b1; b_wd = d; b_wl = last; b_whi = hi;
    for (int k = 0; k < 50; k++) begin
      if (b_wrdy) break;
      tick();
    end
    tick();
  endtask

  task automatic wrC(input logic [7:0] d, input logic last);
    c_wv = 1'b1; c_wd = d; c_wl = last;
    for (int k = 0; k < 50; k++) begin
      if (c_wrdy) break;
      tick();
    end
    tick();
  endtask

  int e3[7] = '{'h21, 'h22, 'h23, 'h24, 'h31, 'h32, 'h33};
  int eB[3] = '{'h11111, 'h12222, 'h000AB};

  initial begin
    int g;
    // Reset state
    tick(); tick();
    checkVal("rst_txvalid", int'(a_txv), 0);
    checkVal("rst_level", int'(a_lvl), 0);
    checkVal("rst_busy", int'(a_busy), 0);
    checkVal("rst_underrun", int'(a_und), 0);
    checkVal("rst_wr_ready", int'(a_wrdy), 0);
    checkVal("rst_dataout", int'(a_dout), 0);
    checkVal("rst_txvalidh16", int'(b_txvh), 0);
    rst = 1'b0;
    tick();
    checkVal("post_rst_wr_ready", int'(a_wrdy), 1);

    // 6-byte packet, TxReady held high
    a_txr = 1'b1;
    for (int i = 1; i <= 6; i++) wrA(8'(i), i == 6);
    a_wv = 1'b0;
    for (int k = 0; k < 50 && a_txv; k++) tick();
    checkVal("t1_txvalid_fell", int'(a_txv), 0);
    g = 0;
    while (a_busy && !a_txv && g < 20) begin g++; tick(); end
    checkVal("t1_gap_cycles", g, 2);
    checkVal("t1_busy_after_gap", int'(a_busy), 0);
    checkVal("t1_level_end", int'(a_lvl), 0);
    checkVal("t1_txvalid_cycles", aTxvCyc, 6);
    checkVal("t1_count", accA.size(), 6);
    for (int i = 0; i < 6; i++)
      checkVal("t1_data", (i < accA.size()) ? accA[i] : -1, i + 1);

    // 4-byte packet, TxReady toggling each cycle
    accA.delete();
    a_txr = 1'b0;
    for (int i = 0; i < 4; i++) wrA(8'('h11 + i), i == 3);
    a_wv = 1'b0;
    for (int k = 0; k < 40; k++) begin a_txr = ~a_txr; tick(); end
    a_txr = 1'b1;
    checkVal("t2_count", accA.size(), 4);
    for (int i = 0; i < 4; i++)
      checkVal("t2_data", (i < accA.size()) ? accA[i] : -1, 'h11 + i);
    checkVal("t2_held_stable", aStab, 0);
    checkVal("t2_idle", int'(a_busy), 0);

    // Underrun mid-packet, then flush and a clean packet
    accA.delete();
    aUndCyc = 0;
    for (int i = 0; i < 4; i++) wrA(8'('h21 + i), 1'b0);
    a_wv = 1'b0;
    repeat (20) tick();
    checkVal("t3_underrun_pulses", aUndCyc, 1);
    checkVal("t3_txvalid_low", int'(a_txv), 0);
    checkVal("t3_flushing", int'(a_busy), 1);
    wrA(8'h25, 1'b0);
    wrA(8'h26, 1'b1);
    a_wv = 1'b0;
    repeat (10) tick();
    checkVal("t3_flushed_idle", int'(a_busy), 0);
    checkVal("t3_flushed_level", int'(a_lvl), 0);
    for (int i = 0; i < 3; i++) wrA(8'('h31 + i), i == 2);
    a_wv = 1'b0;
    repeat (20) tick();
    checkVal("t3_count", accA.size(), 7);
    for (int i = 0; i < 7; i++)
      checkVal("t3_data", (i < accA.size()) ? accA[i] : -1, e3[i]);
    checkVal("t3_underrun_total", aUndCyc, 1);

    // 16-bit: short last word without high byte
    b_txr = 1'b1;
    wrB(16'h1111, 1'b0, 1'b0);
    wrB(16'h2222, 1'b0, 1'b0);
    wrB(16'h00AB, 1'b1, 1'b0);
    b_wv = 1'b0;
    repeat (15) tick();
    checkVal("t4_count", accB.size(), 3);
    for (int i = 0; i < 3; i++)
      checkVal("t4_word_hvalid", (i < accB.size()) ? accB[i] : -1, eB[i]);

    // 4-deep: full backpressure, released by a PHY acceptance
    wrC(8'h61, 1'b0); wrC(8'h62, 1'b0); wrC(8'h63, 1'b0); wrC(8'h64, 1'b0);
    c_wd = 8'h65;
    checkVal("t5_full_ready", int'(c_wrdy), 0);
    checkVal("t5_full_level", int'(c_lvl), 4);
    wrC(8'h65, 1'b0);
    c_wv = 1'b0;
    checkVal("t5_refull_ready", int'(c_wrdy), 0);
    checkVal("t5_refull_level", int'(c_lvl), 4);
    repeat (3) tick();
    checkVal("t5_hold_ready", int'(c_wrdy), 0);
    c_txr = 1'b1;
    tick();
    checkVal("t5_restore_ready", int'(c_wrdy), 1);
    checkVal("t5_restore_level", int'(c_lvl), 3);
    c_txr = 1'b0;
    wrC(8'h66, 1'b1);
    c_wv = 1'b0;
    c_txr = 1'b1;
    repeat (20) tick();
    checkVal("t5_count", accC.size(), 6);
    for (int i = 0; i < 6; i++)
      checkVal("t5_data", (i < accC.size()) ? accC[i] : -1, 'h61 + i);
    checkVal("t5_no_underrun", int'(c_busy), 0);

    // Reset during SEND of a 10-byte packet
    accA.delete();
    a_txr = 1'b0;
    for (int i = 0; i < 10; i++) wrA(8'('h41 + i), i == 9);
    a_wv = 1'b0;
    tick(); tick();
    checkVal("t6_sending", int'(a_txv), 1);
    rst = 1'b1;
    tick();
    checkVal("t6_rst_txvalid", int'(a_txv), 0);
    checkVal("t6_rst_level", int'(a_lvl), 0);
    checkVal("t6_rst_underrun", int'(a_und), 0);
    rst = 1'b0;
    tick();
    a_txr = 1'b1;
    for (int i = 0; i < 3; i++) wrA(8'('h51 + i), i == 2);
    a_wv = 1'b0;
    repeat (15) tick();
    checkVal("t6_count", accA.size(), 3);
    for (int i = 0; i < 3; i++)
      checkVal("t6_data", (i < accA.size()) ? accA[i] : -1, 'h51 + i);
    checkVal("t6_level_end", int'(a_lvl), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

endmodule
